// File: rtl/code_conv_pkg.sv
// Shared types and constants for the code-converter sequencer.
// No logic; no latency or flow control of its own.
package code_conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FWD,
        ST_REV,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [3:0] XS_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX   = 4'd9;

endpackage

// File: rtl/conv_dwell_timer.sv
// Dwell counter for one enable phase: load clears, en counts, last_o flags the final dwell cycle.
// Zero-latency flag from registered count; no backpressure.
module conv_dwell_timer #(
    parameter int STAGE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic last_o
);

    localparam int CNT_W = $clog2(STAGE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at STAGE_CYCLES so a stalled phase can never wrap into a false last cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_W'(STAGE_CYCLES))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = en_i && (cnt_q == CNT_W'(STAGE_CYCLES - 1));

endmodule

// File: rtl/code_conv_sequencer.sv
// Sequences BtoG/BtoXS then GtoB/XStoB enables on a captured operand and checks both round trips.
// start-to-stop latency 3 + 2*STAGE_CYCLES; start ignored while busy, abort returns to idle at once.
module code_conv_sequencer
    import code_conv_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int STAGE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] bus,
    output logic              gcon,
    output logic              xscon,
    output logic              bcon1,
    output logic              bcon2,
    input  logic [DATA_W-1:0] gout,
    input  logic [DATA_W-1:0] xsout,
    input  logic [DATA_W-1:0] bout1,
    input  logic [DATA_W-1:0] bout2,
    output logic [DATA_W-1:0] gray_q,
    output logic [DATA_W-1:0] xs_q,
    output logic              busy,
    output logic              stop,
    output logic              pass,
    output logic              bcd_ovf
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] bus_q, gray_cap_q, xs_cap_q, b1_q, b2_q;
    logic              fwd_en_q, rev_en_q, busy_q, stop_q, pass_q, ovf_q;
    logic              dwell_en, dwell_last;
    logic              accept, cap_fwd, cap_rev, do_check;

    assign dwell_en = (state_q == ST_FWD) || (state_q == ST_REV);

    conv_dwell_timer #(
        .STAGE_CYCLES(STAGE_CYCLES)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (!dwell_en || dwell_last),
        .en_i   (dwell_en),
        .last_o (dwell_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_FWD;
            ST_FWD:   if (dwell_last) state_d = ST_REV;
            ST_REV:   if (dwell_last) state_d = ST_CHECK;
            ST_CHECK: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // Captures are suppressed on abort so results keep their last completed values.
    assign accept   = (state_q == ST_IDLE)  && start      && !abort;
    assign cap_fwd  = (state_q == ST_FWD)   && dwell_last && !abort;
    assign cap_rev  = (state_q == ST_REV)   && dwell_last && !abort;
    assign do_check = (state_q == ST_CHECK) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bus_q      <= '0;
            gray_cap_q <= '0;
            xs_cap_q   <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            fwd_en_q   <= 1'b0;
            rev_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            stop_q     <= 1'b0;
            pass_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            fwd_en_q <= (state_d == ST_FWD) || (state_d == ST_REV);
            rev_en_q <= (state_d == ST_REV);
            busy_q   <= (state_d != ST_IDLE);
            stop_q   <= (state_d == ST_DONE);
            if (accept) begin
                bus_q  <= din;
                pass_q <= 1'b0;
                ovf_q  <= 1'b0;
            end
            if (cap_fwd) begin
                gray_cap_q <= gout;
                xs_cap_q   <= xsout;
            end
            if (cap_rev) begin
                b1_q <= bout1;
                b2_q <= bout2;
            end
            if (do_check) begin
                pass_q <= (b1_q == bus_q) && (b2_q == bus_q);
                ovf_q  <= (bus_q > DATA_W'(BCD_MAX));
            end
        end
    end

    assign bus     = bus_q;
    assign gcon    = fwd_en_q;
    assign xscon   = fwd_en_q;
    assign bcon1   = rev_en_q;
    assign bcon2   = rev_en_q;
    assign gray_q  = gray_cap_q;
    assign xs_q    = xs_cap_q;
    assign busy    = busy_q;
    assign stop    = stop_q;
    assign pass    = pass_q;
    assign bcd_ovf = ovf_q;

endmodule
